// File: rtl/branch_target_unit_if.sv
// Handshake/payload bundle between decode/register-read and the branch target unit.
// The master side issues ops and consumes results; the slave side is the unit.
interface branch_target_unit_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) ();
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_imm;
    logic [4:0]       in_rd_addr;
    logic [4:0]       in_rs1_addr;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [XLEN-1:0]  out_target;
    logic [XLEN-1:0]  out_link;
    logic             out_misaligned;
    logic [XLEN-1:0]  out_ras_pred;
    logic             out_ras_hit;
    logic [CNT_W-1:0] ras_count;

    modport master (
        output in_valid, in_op, in_funct3, in_pc, in_rs1, in_rs2, in_imm,
               in_rd_addr, in_rs1_addr, out_ready,
        input  in_ready, out_valid, out_taken, out_target, out_link,
               out_misaligned, out_ras_pred, out_ras_hit, ras_count
    );

    modport slave (
        input  in_valid, in_op, in_funct3, in_pc, in_rs1, in_rs2, in_imm,
               in_rd_addr, in_rs1_addr, out_ready,
        output in_ready, out_valid, out_taken, out_target, out_link,
               out_misaligned, out_ras_pred, out_ras_hit, ras_count
    );
endinterface

// File: rtl/branch_target_unit.sv
// Single-stage branch target unit: condition evaluation, target/link generation,
// alignment check and a circular return-address stack predicting JALR returns.
module branch_target_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned IALIGN    = 32
) (
    input logic                CLK,
    input logic                RST,
    branch_target_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_BRANCH = 2'd0;
    localparam logic [1:0] OP_JAL    = 2'd1;
    localparam logic [1:0] OP_JALR   = 2'd2;

    logic             out_valid_q, out_valid_d;
    logic             taken_q, taken_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic [XLEN-1:0]  link_q, link_d;
    logic             mis_q, mis_d;
    logic [XLEN-1:0]  pred_q, pred_d;
    logic             hit_q, hit_d;
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];

    logic             capture_c;
    logic             cond_c;
    logic             taken_c;
    logic             mis_c;
    logic             push_c;
    logic             pop_c;
    logic             rd_link_c;
    logic             rs1_link_c;
    logic             nonempty_c;
    logic             hit_c;
    logic [XLEN-1:0]  link_c;
    logic [XLEN-1:0]  pc_imm_c;
    logic [XLEN-1:0]  rs1_imm_c;
    logic [XLEN-1:0]  target_c;
    logic [XLEN-1:0]  pred_c;
    logic [PTR_W-1:0] top_idx_c;
    logic             wr_en_c;
    logic [PTR_W-1:0] wr_idx_c;

    assign capture_c = bus.in_valid && bus.in_ready;
    assign bus.in_ready = !out_valid_q || bus.out_ready;

    assign link_c    = bus.in_pc + XLEN'(4);
    assign pc_imm_c  = bus.in_pc + bus.in_imm;
    assign rs1_imm_c = bus.in_rs1 + bus.in_imm;

    // Branch condition decode; reserved encodings never take.
    always_comb begin
        cond_c = 1'b0;
        case (bus.in_funct3)
            3'b000:  cond_c = (bus.in_rs1 == bus.in_rs2);
            3'b001:  cond_c = (bus.in_rs1 != bus.in_rs2);
            3'b100:  cond_c = ($signed(bus.in_rs1) <  $signed(bus.in_rs2));
            3'b101:  cond_c = ($signed(bus.in_rs1) >= $signed(bus.in_rs2));
            3'b110:  cond_c = (bus.in_rs1 <  bus.in_rs2);
            3'b111:  cond_c = (bus.in_rs1 >= bus.in_rs2);
            default: cond_c = 1'b0;
        endcase
    end

    // Target, alignment and RAS push/pop classification.
    always_comb begin
        taken_c    = 1'b0;
        target_c   = link_c;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        rd_link_c  = (bus.in_rd_addr == 5'd1) || (bus.in_rd_addr == 5'd5);
        rs1_link_c = (bus.in_rs1_addr == 5'd1) || (bus.in_rs1_addr == 5'd5);
        case (bus.in_op)
            OP_BRANCH: begin
                taken_c  = cond_c;
                target_c = cond_c ? pc_imm_c : link_c;
            end
            OP_JAL: begin
                taken_c  = 1'b1;
                target_c = pc_imm_c;
                push_c   = rd_link_c;
            end
            OP_JALR: begin
                taken_c  = 1'b1;
                target_c = {rs1_imm_c[XLEN-1:1], 1'b0};
                push_c   = rd_link_c;
                pop_c    = rs1_link_c && !(rd_link_c && (bus.in_rd_addr == bus.in_rs1_addr));
            end
            default: begin
                taken_c  = 1'b0;
                target_c = link_c;
            end
        endcase
        if (IALIGN == 16) begin
            mis_c = taken_c && target_c[0];
        end else begin
            mis_c = taken_c && (target_c[1:0] != 2'b00);
        end
    end

    assign nonempty_c = (cnt_q != '0);
    assign top_idx_c  = PTR_W'(sp_q - 1'b1);
    assign pred_c     = (pop_c && nonempty_c) ? ras_q[top_idx_c] : '0;
    assign hit_c      = pop_c && nonempty_c && (pred_c == target_c);

    // Next-state for the result register and the stack pointer/count.
    always_comb begin
        out_valid_d = out_valid_q;
        taken_d     = taken_q;
        target_d    = target_q;
        link_d      = link_q;
        mis_d       = mis_q;
        pred_d      = pred_q;
        hit_d       = hit_q;
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        wr_en_c     = 1'b0;
        wr_idx_c    = sp_q;
        if (capture_c) begin
            out_valid_d = 1'b1;
            taken_d     = taken_c;
            target_d    = target_c;
            link_d      = link_c;
            mis_d       = mis_c;
            pred_d      = pred_c;
            hit_d       = hit_c;
            if (pop_c && nonempty_c && push_c) begin
                wr_en_c  = 1'b1;
                wr_idx_c = top_idx_c;
            end else if (pop_c && nonempty_c) begin
                sp_d  = top_idx_c;
                cnt_d = CNT_W'(cnt_q - 1'b1);
            end else if (push_c) begin
                // A full stack overwrites its oldest slot, which is the write slot.
                wr_en_c  = 1'b1;
                wr_idx_c = sp_q;
                sp_d     = PTR_W'(sp_q + 1'b1);
                if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            link_q      <= '0;
            mis_q       <= 1'b0;
            pred_q      <= '0;
            hit_q       <= 1'b0;
            sp_q        <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            link_q      <= link_d;
            mis_q       <= mis_d;
            pred_q      <= pred_d;
            hit_q       <= hit_d;
            sp_q        <= sp_d;
            cnt_q       <= cnt_d;
        end
    end

    // Stack contents carry no reset; only pointer and count define liveness.
    always_ff @(posedge CLK) begin
        if (wr_en_c && !RST) begin
            ras_q[wr_idx_c] <= link_c;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_taken      = taken_q;
    assign bus.out_target     = target_q;
    assign bus.out_link       = link_q;
    assign bus.out_misaligned = mis_q;
    assign bus.out_ras_pred   = pred_q;
    assign bus.out_ras_hit    = hit_q;
    assign bus.ras_count      = cnt_q;
endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
- Parametrised, single-stage pipelined successor to the combinational branch address generator.
- Computes the control-flow target for BRANCH/JAL/JALR/NONE ops and evaluates the branch condition internally.
- Flags misaligned targets and maintains a return-address stack (RAS) that predicts JALR returns.
- Sits between decode/register-read and the PC-select/fetch redirect logic, with valid/ready handshakes on both sides.

Parameters:
XLEN, 32, datapath/address width in bits (>=16)
RAS_DEPTH, 4, number of RAS entries (power of two, >=2)
IALIGN, 32, instruction alignment in bits (32 or 16)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
in_valid  input  1  input op present
in_ready  output  1  unit can accept op this cycle
in_op  input  2  0=BRANCH, 1=JAL, 2=JALR, 3=NONE
in_funct3  input  3  branch condition (BRANCH only)
in_pc  input  XLEN  PC of the op
in_rs1  input  XLEN  rs1 value
in_rs2  input  XLEN  rs2 value
in_imm  input  XLEN  sign-extended immediate (B/J/I already selected by decode)
in_rd_addr  input  5  destination register index
in_rs1_addr  input  5  rs1 register index
out_valid  output  1  result registered and valid
out_ready  input  1  consumer accepts result
out_taken  output  1  control transfer taken
out_target  output  XLEN  next PC
out_link  output  XLEN  in_pc+4 (return address)
out_misaligned  output  1  taken target violates IALIGN
out_ras_pred  output  XLEN  RAS top used for the prediction (0 if none)
out_ras_hit  output  1  pop op, stack non-empty, prediction == out_target
ras_count  output  $clog2(RAS_DEPTH)+1  live RAS entry count

Behaviour:
- Reset (sync, RST high at edge): out_valid=0, all out_* data=0, ras_count=0, RAS pointer=0. Reset overrides any capture in the same cycle. Reset mid-operation discards the held result. RAS entry contents are don't-care.
- Handshake: in_ready = !out_valid || out_ready (combinational).
  - Capture occurs when in_valid && in_ready; results appear next cycle (latency 1).
  - out_valid set on capture; cleared when out_ready && !capture.
  - While out_valid && !out_ready, all out_* hold stable and the RAS does not change.
  - Back-to-back ops sustain 1 op/cycle when out_ready=1.
- Arithmetic: all adds are modulo 2^XLEN; wrap-around is silent.
  - BRANCH: target = taken ? pc+imm : pc+4. Condition by funct3:
    - 000 EQ; 001 NE; 100 signed LT; 101 signed GE; 110 unsigned LT; 111 unsigned GE.
    - 010/011 give taken=0.
  - JAL: target = pc+imm, taken=1.
  - JALR: target = (rs1+imm) with bit0 forced 0, taken=1.
  - NONE: target = pc+4, taken=0.
  - link = pc+4 for every op.
- Misalignment:
  - IALIGN=32: misaligned = taken && target[1:0]!=0.
  - IALIGN=16: misaligned = taken && target[0].
  - Not-taken never flags.
- RAS (updated only on capture; link reg = x1 or x5):
  - JAL, rd link: push.
  - JALR, rd not link, rs1 link: pop.
  - JALR, rd link, rs1 not link: push.
  - JALR, both link, rd==rs1: push.
  - JALR, both link, rd!=rs1: pop then push (replace top; count unchanged, or 1 if empty).
  - All other ops: no RAS change.
  - Push value = pc+4. Push when full overwrites the oldest entry (circular) and ras_count saturates at RAS_DEPTH.
  - Pop when empty: no change, out_ras_pred=0, out_ras_hit=0.
  - For pop ops, out_ras_pred = top before the pop. For non-pop ops, out_ras_pred=0 and out_ras_hit=0.
  - RAS updates regardless of misalignment.

Test Plan:
- Reset, then BRANCH funct3=000, pc=0x100, imm=0x20, rs1=rs2=5 -> next cycle out_valid=1, taken=1, target=0x120, link=0x104.
- BLT vs BLTU, rs1=0xFFFFFFFF, rs2=1 -> BLT (100) taken=1; BLTU (110) taken=0, target=pc+4; funct3=010 -> taken=0.
- JALR, rs1=0x1003, imm=0 -> target=0x1002 (bit0 cleared), misaligned=1 at IALIGN=32 and 0 at IALIGN=16.
- JAL rd=x1 at pc=0x200 (push 0x204), then JALR rd=x0 rs1=x1 rs1=0x204 -> out_ras_pred=0x204, out_ras_hit=1, ras_count 1->0; second identical pop -> ras_pred=0, hit=0, count stays 0.
- Five JAL rd=x1 pushes (pc 0x10..0x50) with RAS_DEPTH=4 -> count=4, then pops predict 0x54, 0x44, 0x34, 0x24.
- Hold out_ready=0 with in_valid=1 for 3 cycles -> in_ready=0, outputs and ras_count frozen. Assert RST mid-stall -> out_valid=0, ras_count=0 next cycle. pc=0xFFFFFFFC, NONE -> target=0x0.
